// File: rtl/ram_port_arbiter.sv
// Three-requester round-robin arbiter for one solver RAM bank with IO priority and bounded locking.
// Grant is combinational in cycle t, RAM command registered at t+1, tagged read return at t+2; losers wait by holding req.
module ram_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 64,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_mode,
  input  logic              req0,
  input  logic              req1,
  input  logic              req2,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              lock2,
  input  logic              wr0,
  input  logic              wr1,
  input  logic              wr2,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic              gnt0,
  output logic              gnt1,
  output logic              gnt2,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              rvalid2,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_WR_RD,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CW = 4;
  localparam logic [CW-1:0] MAX_LOCK_C = CW'(MAX_LOCK);

  logic [3:0]        req_x;
  logic [3:0]        lock_x;
  logic [1:0]        ptr_q;
  logic              lock_vld_q;
  logic [1:0]        lock_id_q;
  logic [CW-1:0]     lock_cnt_q;
  logic              ram_en_q;
  logic              ram_wr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              tag1_vld_q, tag2_vld_q;
  logic [1:0]        tag1_id_q, tag2_id_q;

  logic              gnt_vld_d;
  logic [1:0]        gnt_id_d;
  logic              lock_ok;
  logic              lock_expired;
  logic              wr_sel;
  logic              lock_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [2:0]        rr_pick;
  logic [2:0]        gnt_vec;

  // Padding to four bits lets a 2-bit id index the vector without range checks.
  assign req_x  = {1'b0, req2, req1, req0};
  assign lock_x = {1'b0, lock2, lock1, lock0};

  assign lock_expired = lock_vld_q && (lock_cnt_q >= MAX_LOCK_C);
  assign lock_ok      = lock_vld_q && req_x[lock_id_q] && !lock_expired;

  always_comb begin
    logic [1:0] idx;
    rr_pick = 3'b000;
    idx     = ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!rr_pick[2] && req_x[idx]) rr_pick = {1'b1, idx};
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_id_d  = 2'd0;
    if (rst) begin
      if (io_mode && req0) begin
        gnt_vld_d = 1'b1;
        gnt_id_d  = 2'd0;
      end else if (lock_ok) begin
        gnt_vld_d = 1'b1;
        gnt_id_d  = lock_id_q;
      end else begin
        gnt_vld_d = rr_pick[2];
        gnt_id_d  = rr_pick[1:0];
      end
    end
  end

  always_comb begin
    wr_sel    = wr0;
    addr_sel  = addr0;
    wdata_sel = wdata0;
    case (gnt_id_d)
      2'd1: begin wr_sel = wr1; addr_sel = addr1; wdata_sel = wdata1; end
      2'd2: begin wr_sel = wr2; addr_sel = addr2; wdata_sel = wdata2; end
      default: ;
    endcase
  end

  assign lock_sel = lock_x[gnt_id_d];
  assign gnt_vec  = gnt_vld_d ? (3'b001 << gnt_id_d) : 3'b000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= 2'd0;
      lock_vld_q  <= 1'b0;
      lock_id_q   <= 2'd0;
      lock_cnt_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_id_q   <= 2'd0;
      tag2_vld_q  <= 1'b0;
      tag2_id_q   <= 2'd0;
    end else begin
      ram_en_q   <= gnt_vld_d;
      tag1_vld_q <= gnt_vld_d && !wr_sel;
      tag1_id_q  <= gnt_id_d;
      tag2_vld_q <= tag1_vld_q;
      tag2_id_q  <= tag1_id_q;
      if (gnt_vld_d) begin
        ram_wr_q    <= wr_sel;
        ram_addr_q  <= addr_sel;
        ram_wdata_q <= wdata_sel;
        ptr_q       <= (gnt_id_d == 2'd2) ? 2'd0 : gnt_id_d + 2'd1;
        // An expired lock forces one free arbitration before anyone can lock again.
        if (!lock_expired && lock_sel) begin
          lock_vld_q <= 1'b1;
          lock_id_q  <= gnt_id_d;
          lock_cnt_q <= (lock_vld_q && lock_id_q == gnt_id_d) ? lock_cnt_q + 1'b1 : CW'(1);
        end else begin
          lock_vld_q <= 1'b0;
          lock_cnt_q <= '0;
        end
      end else begin
        ram_wr_q   <= 1'b0;
        lock_vld_q <= 1'b0;
        lock_cnt_q <= '0;
      end
    end
  end

  assign {gnt2, gnt1, gnt0} = gnt_vec;
  assign ram_en      = ram_en_q;
  assign ram_WR_RD   = ram_wr_q;
  assign ram_address = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign rdata       = ram_rdata;
  assign rvalid0     = tag2_vld_q && (tag2_id_q == 2'd0);
  assign rvalid1     = tag2_vld_q && (tag2_id_q == 2'd1);
  assign rvalid2     = tag2_vld_q && (tag2_id_q == 2'd2);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a one-cycle-latency RAM model.
module tb_ram_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 64;

  logic clk, rst, io_mode;
  logic req0, req1, req2, lock0, lock1, lock2, wr0, wr1, wr2;
  logic [ADDR_W-1:0] addr0, addr1, addr2;
  logic [DATA_W-1:0] wdata0, wdata1, wdata2;
  logic gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2;
  logic [DATA_W-1:0] rdata, ram_wdata, ram_rdata;
  logic ram_en, ram_WR_RD;
  logic [ADDR_W-1:0] ram_address;

  logic [DATA_W-1:0] mem [0:4095];
  int n_cmp = 0;
  int n_err = 0;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(8)) dut (
    .clk(clk), .rst(rst), .io_mode(io_mode),
    .req0(req0), .req1(req1), .req2(req2),
    .lock0(lock0), .lock1(lock1), .lock2(lock2),
    .wr0(wr0), .wr1(wr1), .wr2(wr2),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rvalid2(rvalid2),
    .rdata(rdata), .ram_en(ram_en), .ram_WR_RD(ram_WR_RD),
    .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_WR_RD) mem[ram_address] <= ram_wdata;
      else ram_rdata <= mem[ram_address];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    io_mode = 0;
    {req2, req1, req0} = 3'b000;
    {lock2, lock1, lock0} = 3'b000;
    {wr2, wr1, wr0} = 3'b000;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    {req2, req1, req0} = 3'b111;
    addr0 = 12'h111; addr1 = 12'h222; addr2 = 12'h333;
    wdata0 = 64'hA0; wdata1 = 64'hA1; wdata2 = 64'hA2;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({gnt2, gnt1, gnt0} !== 3'b000) begin
      n_err++; $display("FAIL reset_gnt: got %b, required 000", {gnt2, gnt1, gnt0});
    end
    n_cmp++;
    if ({ram_en, ram_WR_RD} !== 2'b00 || ram_address !== 12'h0 || ram_wdata !== 64'h0) begin
      n_err++; $display("FAIL reset_ram: got en=%b wr=%b a=%h d=%h, required all 0",
                        ram_en, ram_WR_RD, ram_address, ram_wdata);
    end
    n_cmp++;
    if ({rvalid2, rvalid1, rvalid0} !== 3'b000) begin
      n_err++; $display("FAIL reset_rvalid: got %b, required 000", {rvalid2, rvalid1, rvalid0});
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_round_robin();
    logic [2:0]        exp_g;
    logic [ADDR_W-1:0] exp_a;
    {wr2, wr1, wr0} = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_g = 3'b001 << (k % 3);
      exp_a = (k % 3 == 0) ? 12'h111 : (k % 3 == 1) ? 12'h222 : 12'h333;
      #1;
      n_cmp++;
      if ({gnt2, gnt1, gnt0} !== exp_g) begin
        n_err++; $display("FAIL rr_gnt[%0d]: got %b, required %b", k, {gnt2, gnt1, gnt0}, exp_g);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (ram_en !== 1'b1 || ram_address !== exp_a) begin
        n_err++; $display("FAIL rr_addr[%0d]: got en=%b a=%h, required en=1 a=%h", k, ram_en, ram_address, exp_a);
      end
      @(negedge clk);
    end
    idle_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if (ram_en !== 1'b0 || ram_WR_RD !== 1'b0 || ram_address !== 12'h333) begin
      n_err++; $display("FAIL idle_cmd: got en=%b wr=%b a=%h, required en=0 wr=0 a=333", ram_en, ram_WR_RD, ram_address);
    end
    @(negedge clk);
  endtask

  task automatic test_read_return();
    req1 = 1; wr1 = 0; addr1 = 12'h385;
    #1;
    n_cmp++;
    if ({gnt2, gnt1, gnt0} !== 3'b010) begin
      n_err++; $display("FAIL rd_gnt: got %b, required 010", {gnt2, gnt1, gnt0});
    end
    @(posedge clk); #1;
    req1 = 0;
    n_cmp++;
    if (ram_en !== 1'b1 || ram_WR_RD !== 1'b0 || ram_address !== 12'h385 || rvalid1 !== 1'b0) begin
      n_err++; $display("FAIL rd_cmd: got en=%b wr=%b a=%h rv1=%b, required 1 0 385 0", ram_en, ram_WR_RD, ram_address, rvalid1);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({rvalid2, rvalid1, rvalid0} !== 3'b010 || rdata !== 64'hDEAD_BEEF) begin
      n_err++; $display("FAIL rd_return: got rv=%b d=%h, required rv=010 d=deadbeef", {rvalid2, rvalid1, rvalid0}, rdata);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({rvalid2, rvalid1, rvalid0} !== 3'b000) begin
      n_err++; $display("FAIL rd_single: got rv=%b, required 000", {rvalid2, rvalid1, rvalid0});
    end
    @(negedge clk);
  endtask

  task automatic test_lock_bound();
    logic [2:0] exp_g;
    req2 = 1; lock2 = 1; req0 = 1; wr2 = 1; wr0 = 1;
    for (int k = 0; k < 10; k++) begin
      exp_g = (k == 8) ? 3'b001 : 3'b100;
      #1;
      n_cmp++;
      if ({gnt2, gnt1, gnt0} !== exp_g) begin
        n_err++; $display("FAIL lock_gnt[%0d]: got %b, required %b", k, {gnt2, gnt1, gnt0}, exp_g);
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_io_priority();
    logic [2:0] exp_g;
    req2 = 1; lock2 = 1; wr2 = 1;
    #1;
    n_cmp++;
    if ({gnt2, gnt1, gnt0} !== 3'b100) begin
      n_err++; $display("FAIL io_prelock: got %b, required 100", {gnt2, gnt1, gnt0});
    end
    @(negedge clk);
    io_mode = 1; {req2, req1, req0} = 3'b111; {wr2, wr1, wr0} = 3'b111;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) io_mode = 0;
      exp_g = (k < 4) ? 3'b001 : (k == 4) ? 3'b010 : 3'b100;
      #1;
      n_cmp++;
      if ({gnt2, gnt1, gnt0} !== exp_g) begin
        n_err++; $display("FAIL io_gnt[%0d]: got %b, required %b", k, {gnt2, gnt1, gnt0}, exp_g);
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    req0 = 1; wr0 = 0; addr0 = 12'h007;
    @(posedge clk); #1;
    req0 = 0;
    #1 rst = 0;
    #1;
    n_cmp++;
    if (ram_en !== 1'b0 || ram_address !== 12'h0) begin
      n_err++; $display("FAIL mid_rst_cmd: got en=%b a=%h, required en=0 a=000", ram_en, ram_address);
    end
    @(negedge clk);
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rvalid0 !== 1'b0 || ram_en !== 1'b0) begin
        n_err++; $display("FAIL mid_rst_rv[%0d]: got rv0=%b en=%b, required 0 0", k, rvalid0, ram_en);
      end
    end
    @(negedge clk);
    req0 = 1; req1 = 1; wr0 = 1; wr1 = 1;
    #1;
    n_cmp++;
    if ({gnt2, gnt1, gnt0} !== 3'b001) begin
      n_err++; $display("FAIL mid_rst_first: got %b, required 001", {gnt2, gnt1, gnt0});
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    req0 = 1; wr0 = 1; addr0 = 12'h005; wdata0 = 64'h1;
    #1;
    n_cmp++;
    if ({gnt2, gnt1, gnt0} !== 3'b001) begin
      n_err++; $display("FAIL b2b_gnt_wr: got %b, required 001", {gnt2, gnt1, gnt0});
    end
    @(negedge clk);
    req0 = 0; req1 = 1; wr1 = 0; addr1 = 12'h005;
    #1;
    n_cmp++;
    if ({gnt2, gnt1, gnt0} !== 3'b010 || ram_WR_RD !== 1'b1 || ram_wdata !== 64'h1) begin
      n_err++; $display("FAIL b2b_wr_cmd: got g=%b wr=%b d=%h, required 010 1 1", {gnt2, gnt1, gnt0}, ram_WR_RD, ram_wdata);
    end
    @(posedge clk); #1;
    req1 = 0;
    n_cmp++;
    if (ram_WR_RD !== 1'b0 || ram_address !== 12'h005 || ram_en !== 1'b1) begin
      n_err++; $display("FAIL b2b_rd_cmd: got wr=%b a=%h en=%b, required 0 005 1", ram_WR_RD, ram_address, ram_en);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({rvalid2, rvalid1, rvalid0} !== 3'b010 || rdata !== 64'h1) begin
      n_err++; $display("FAIL b2b_return: got rv=%b d=%h, required 010 1", {rvalid2, rvalid1, rvalid0}, rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 64'h0;
    mem[12'h385] = 64'hDEAD_BEEF;
    ram_rdata = 64'h0;
    test_reset();
    test_round_robin();
    test_read_return();
    test_lock_bound();
    test_io_priority();
    test_reset_mid_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
